// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes, FSM states, lane masks.
package dmem_pkg;

    localparam int WORDS = 128;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = 4'b0011 << off;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Illegal size counts as misaligned so a single flag drives rsp_err.
    function automatic logic misaligned(input mem_size_t size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load lane select plus sign/zero extension of the selected byte/half/word.
module dmem_load_ext
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  mem_size_t         size_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[8*off_i +: 8];
    assign half_sel = word_i[16*off_i[1] +: 16];

    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{(DATA_W-8){signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{(DATA_W-16){signed_i & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stores commit on accept and answer next cycle; loads answer after a
// programmable wait. req_ready only in IDLE; mem_stall holds the pipeline until rsp_valid.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int WAIT_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_stall
);

    localparam int NWORDS = 2**(DM_ADDRESS-2);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    mem_size_t             size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_W-1:0]     mem_q [NWORDS];

    mem_size_t             req_sz;
    logic                  accept;
    logic                  req_bad;
    logic [3:0]            wr_mask;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W-1:0]     ld_ext;

    assign req_sz  = mem_size_t'(req_size);
    assign accept  = req_valid && req_ready;
    assign req_bad = misaligned(req_sz, req_addr[1:0]);
    assign wr_mask = lane_mask(req_sz, req_addr[1:0]);

    always_comb begin
        wr_data = req_wdata;
        case (req_sz)
            SZ_BYTE: wr_data = {4{req_wdata[7:0]}};
            SZ_HALF: wr_data = {2{req_wdata[15:0]}};
            default: wr_data = req_wdata;
        endcase
    end

    dmem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .word_i   (mem_q[addr_q[DM_ADDRESS-1:2]]),
        .off_i    (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .data_o   (ld_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    size_d  = req_sz;
                    sgn_d   = req_signed;
                    rdata_d = '0;
                    err_d   = req_bad;
                    cnt_d   = 4'(WAIT_CYC);
                    state_d = (req_we || req_bad) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately unreset so it maps onto a RAM and survives reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem_q[req_addr[DM_ADDRESS-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_stall = req_valid && !rsp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

    localparam int WAIT_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_stall;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  ref_mem [512];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYC(WAIT_CYC)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_stall  (mem_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [8:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd2 && (a % 4) != 0) || (sz == 2'd1 && (a % 2) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        if (sz == 2'd0) begin
            b = ref_mem[a];
            return sgn ? 32'($signed(b)) : {24'd0, b};
        end else if (sz == 2'd1) begin
            h = {ref_mem[a+1], ref_mem[a]};
            return sgn ? 32'($signed(h)) : {16'd0, h};
        end
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic ref_store(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a+i] = d[8*i +: 8];
    endtask

    task automatic do_req(input string tag, input logic we, input logic [8:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic sgn);
        logic        e;
        logic [31:0] exp_data;
        int          exp_lat;
        int          lat;
        logic        stall_ok;
        logic        ready_ok;
        e        = ref_err(a, sz);
        exp_data = (we || e) ? 32'd0 : ref_load(a, sz, sgn);
        exp_lat  = (we || e) ? 1 : WAIT_CYC + 2;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_signed = sgn;
        req_valid = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        if (we && !e) ref_store(a, sz, d);
        #1;
        lat      = 1;
        stall_ok = 1'b1;
        ready_ok = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (mem_stall !== 1'b1) stall_ok = 1'b0;
            if (req_ready !== 1'b0) ready_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".stall_wait"}, 32'(stall_ok), 32'd1);
        chk({tag, ".ready_busy"}, 32'(ready_ok), 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, exp_data);
        chk({tag, ".err"}, 32'(rsp_err), 32'(e));
        chk({tag, ".stall_rsp"}, 32'(mem_stall), 32'd0);
        last_rdata = rsp_rdata;
        req_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".hold"}, rsp_rdata, exp_data);
    endtask

    initial begin
        int no_rsp;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = '0; req_signed = 1'b0;
        #12;
        chk("reset.ready", 32'(req_ready), 32'd1);
        chk("reset.valid", 32'(rsp_valid), 32'd0);
        chk("reset.rdata", rsp_rdata, 32'd0);
        chk("reset.err", 32'(rsp_err), 32'd0);
        chk("reset.stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("sw", 1'b1, 9'h010, 32'h8765_4321, 2'd2, 1'b0);
        do_req("lw", 1'b0, 9'h010, 32'd0, 2'd2, 1'b0);
        chk("lw.const", last_rdata, 32'h8765_4321);
        do_req("lb", 1'b0, 9'h013, 32'd0, 2'd0, 1'b1);
        chk("lb.const", last_rdata, 32'hFFFF_FF87);
        do_req("lbu", 1'b0, 9'h013, 32'd0, 2'd0, 1'b0);
        chk("lbu.const", last_rdata, 32'h0000_0087);
        do_req("lh", 1'b0, 9'h012, 32'd0, 2'd1, 1'b1);
        chk("lh.const", last_rdata, 32'hFFFF_8765);
        do_req("lhu", 1'b0, 9'h010, 32'd0, 2'd1, 1'b0);
        chk("lhu.const", last_rdata, 32'h0000_4321);

        do_req("sb", 1'b1, 9'h011, 32'h0000_00AA, 2'd0, 1'b0);
        do_req("lw_sb", 1'b0, 9'h010, 32'd0, 2'd2, 1'b0);
        chk("lw_sb.const", last_rdata, 32'h8765_AA21);
        do_req("sh", 1'b1, 9'h012, 32'h0000_BEEF, 2'd1, 1'b0);
        do_req("lw_sh", 1'b0, 9'h010, 32'd0, 2'd2, 1'b0);
        chk("lw_sh.const", last_rdata, 32'hBEEF_AA21);

        do_req("err_lw", 1'b0, 9'h011, 32'd0, 2'd2, 1'b0);
        do_req("err_sh", 1'b1, 9'h013, 32'h0000_1234, 2'd1, 1'b0);
        do_req("err_ill", 1'b1, 9'h000, 32'hDEAD_BEEF, 2'd3, 1'b0);
        do_req("lw_err", 1'b0, 9'h010, 32'd0, 2'd2, 1'b0);
        chk("lw_err.const", last_rdata, 32'hBEEF_AA21);

        // Abandon a load while it is waiting on the array.
        @(negedge clk);
        req_we = 1'b0; req_addr = 9'h010; req_size = 2'd2; req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.ready_wait", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ready", 32'(req_ready), 32'd1);
        chk("rst_mid.valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid.rdata", rsp_rdata, 32'd0);
        chk("rst_mid.err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        no_rsp = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) no_rsp = 0;
        end
        chk("rst_mid.no_rsp", 32'(no_rsp), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid.ready_after", 32'(req_ready), 32'd1);
        do_req("lw_rst", 1'b0, 9'h010, 32'd0, 2'd2, 1'b0);
        chk("lw_rst.const", last_rdata, 32'hBEEF_AA21);

        for (int w = 0; w < 16; w++) begin
            do_req("init", 1'b1, 9'(w * 4), $urandom, 2'd2, 1'b0);
        end
        for (int n = 0; n < 60; n++) begin
            do_req("rand", 1'($urandom_range(0, 1)), 9'($urandom_range(0, 63)), $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
